// File: rtl/ofifo_simd_pkg.sv
// Shared definitions for the SIMD output collector: mode encoding, lane-merge
// shift and the per-column FIFO pointer width.
package ofifo_simd_pkg;

  typedef enum logic {
    MODE_4B = 1'b0,
    MODE_2B = 1'b1
  } mode_e;

  // s1 carries the upper 2-bit activation half, worth 4x the lower half.
  localparam int ACT_HALF_SHIFT = 2;

  // Address bits plus one wrap bit.
  function automatic int ptr_bw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ofifo_simd_if.sv
// Bus between the MAC array bottom tile / downstream consumer and ofifo_simd.
interface ofifo_simd_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0]   in_s0;
  logic [col*psum_bw-1:0]   in_s1;
  logic [col-1:0]           wr;
  logic                     cfg_2b;
  logic                     rd;
  logic [col*2*psum_bw-1:0] out;
  logic                     o_valid;
  logic                     o_full;
  logic                     o_ovf;

  modport master (
    output in_s0, in_s1, wr, cfg_2b, rd,
    input  out, o_valid, o_full, o_ovf
  );

  modport slave (
    input  in_s0, in_s1, wr, cfg_2b, rd,
    output out, o_valid, o_full, o_ovf
  );
endinterface

// File: rtl/ofifo_col.sv
// Single-column first-word-fall-through synchronous FIFO with wrap-bit
// pointers; a push into a full FIFO is accepted only alongside a pop.
module ofifo_col
  import ofifo_simd_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int pw = ptr_bw(depth);
  localparam int aw = pw - 1;
  localparam logic [pw-1:0] one = 1;

  logic [pw-1:0]    wr_ptr, rd_ptr;
  logic [width-1:0] mem [depth];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + one;
      if (do_pop)  rd_ptr <= rd_ptr + one;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_simd.sv
// Output collector below the SIMD MAC array: merges/keeps each column's psum
// pair per mode and buffers it in a per-column FIFO. Optional: OFIFO_SIMD_RELU_EN.
module ofifo_simd
  import ofifo_simd_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input logic         clk,
  input logic         reset,
  ofifo_simd_if.slave bus
);
  localparam int lw = 2 * psum_bw;

  logic [col-1:0] full, empty;
  logic           valid, pop, ovf;

  assign valid       = ~|empty;
  assign pop         = bus.rd && valid;
  assign bus.o_valid = valid;
  assign bus.o_full  = |full;
  assign bus.o_ovf   = ovf;

  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] s0, s1, m, l0, l1;
    logic [lw-1:0]      head;

    assign s0 = bus.in_s0[g*psum_bw +: psum_bw];
    assign s1 = bus.in_s1[g*psum_bw +: psum_bw];
    // Modulo-2^psum_bw arithmetic equals sign-extend, add, then truncate.
    assign m  = s0 + (s1 << ACT_HALF_SHIFT);

    // NOTE: combinational blocks use blocking assignments, defaults set first, so no latch is inferred.
    always_comb begin
      l0 = m;
      l1 = '0;
      if (mode_e'(bus.cfg_2b) == MODE_2B) begin
        l0 = s0;
        l1 = s1;
      end
`ifdef OFIFO_SIMD_RELU_EN
      if (l0[psum_bw-1]) l0 = '0;
      if (l1[psum_bw-1]) l1 = '0;
`endif
    end

    ofifo_col #(
      .width(lw),
      .depth(depth)
    ) u_col (
      .clk  (clk),
      .reset(reset),
      .push (bus.wr[g]),
      .pop  (pop),
      .din  ({l1, l0}),
      .dout (head),
      .full (full[g]),
      .empty(empty[g])
    );

    assign bus.out[g*lw +: lw] = valid ? head : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (|(bus.wr & full & ~{col{pop}})) begin
      ovf <= 1'b1;
    end
  end

endmodule
